// File: rtl/fft_pkg.sv
// Shared types and butterfly arithmetic for the streaming SDF FFT.
// Used by the butterfly stages and the twiddle multiplier.
package fft_pkg;

   localparam int DW = 16;
   localparam int CPLX_W = 2 * DW;

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } bf_state_t;

   // (a+b)/2 on 17 bits, floor rounding; cannot overflow
   function automatic logic signed [DW-1:0] half_add(
      input logic signed [DW-1:0] a,
      input logic signed [DW-1:0] b
   );
      logic signed [DW:0] s;
      s = (DW+1)'(a) + (DW+1)'(b);
      return DW'(s >>> 1);
   endfunction

   // (a-b)/2 on 17 bits, floor rounding; cannot overflow
   function automatic logic signed [DW-1:0] half_sub(
      input logic signed [DW-1:0] a,
      input logic signed [DW-1:0] b
   );
      logic signed [DW:0] s;
      s = (DW+1)'(a) - (DW+1)'(b);
      return DW'(s >>> 1);
   endfunction

   function automatic cplx_t cplx_half_add(
      input cplx_t a,
      input cplx_t b
   );
      cplx_t r;
      r.re = half_add(a.re, b.re);
      r.im = half_add(a.im, b.im);
      return r;
   endfunction

   function automatic cplx_t cplx_half_sub(
      input cplx_t a,
      input cplx_t b
   );
      cplx_t r;
      r.re = half_sub(a.re, b.re);
      r.im = half_sub(a.im, b.im);
      return r;
   endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// DEPTH-word feedback delay; Q is the word written DEPTH enables ago.
// Circular RAM, advances only when EN is high.
module sdf_delay_line
   import fft_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              CLK,
   input  logic              EN,
   input  logic [CPLX_W-1:0] D,
   output logic [CPLX_W-1:0] Q
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CPLX_W-1:0] mem [DEPTH];
   logic [AW-1:0]     ptr;

   // oldest slot is the one about to be overwritten
   assign Q = mem[ptr];

   // write the new word over the oldest one and step the pointer
   always_ff @(posedge CLK) begin
      if (EN) begin
         mem[ptr] <= D;
         if (ptr == AW'(DEPTH - 1)) begin
            ptr <= '0;
         end else begin
            ptr <= ptr + AW'(1);
         end
      end
   end

endmodule

// File: rtl/r2sdf_bf_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage.
// Emits sums (phase 1) and stored differences with twiddle index (phase 0).
module r2sdf_bf_stage
   import fft_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int TW_W      = 3,
   parameter int TW_STRIDE = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              DI_VALID,
   input  logic [CPLX_W-1:0] DI,
   output logic              DO_VALID,
   output logic [CPLX_W-1:0] DO,
   output logic [TW_W-1:0]   TW_IDX,
   output logic              DO_DIFF
);

   localparam int CW = $clog2(2 * DEPTH);
   localparam int KW = (CW > 1) ? CW - 1 : 1;

   bf_state_t         state;
   logic [CW-1:0]     cnt;
   logic              phase;
   logic [KW-1:0]     k;
   logic              beat;

   cplx_t             di_c;
   cplx_t             d_c;
   logic [CPLX_W-1:0] d_raw;
   cplx_t             sum_c;
   cplx_t             dif_c;
   cplx_t             push_c;

   cplx_t             cand;
   logic [TW_W-1:0]   cand_tw;
   logic              cand_diff;
   logic [31:0]       tw_full;

   // a beat coinciding with reset is dropped entirely
   assign beat  = DI_VALID && !RST;
   assign phase = cnt[CW-1];
   assign k     = KW'(cnt & CW'(DEPTH - 1));

   assign di_c  = cplx_t'(DI);
   assign d_c   = cplx_t'(d_raw);
   assign sum_c = cplx_half_add(d_c, di_c);
   assign dif_c = cplx_half_sub(d_c, di_c);

   assign tw_full = 32'(k) * 32'(TW_STRIDE);

   sdf_delay_line #(
      .DEPTH (DEPTH)
   ) u_dly (
      .CLK (CLK),
      .EN  (beat),
      .D   (push_c),
      .Q   (d_raw)
   );

   // phase 0 stores input and drains old differences; phase 1 does the butterfly
   always_comb begin
      push_c    = di_c;
      cand      = d_c;
      cand_tw   = TW_W'(tw_full);
      cand_diff = 1'b1;
      if (phase) begin
         push_c    = dif_c;
         cand      = sum_c;
         cand_tw   = '0;
         cand_diff = 1'b0;
      end
   end

   // frame counter, fill/run control and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= FILL;
         cnt      <= '0;
         DO_VALID <= 1'b0;
         DO       <= '0;
         TW_IDX   <= '0;
         DO_DIFF  <= 1'b0;
      end else begin
         DO_VALID <= 1'b0;
         if (DI_VALID) begin
            cnt <= cnt + CW'(1);
            unique case (state)
               FILL: begin
                  if (cnt == CW'(DEPTH - 1)) begin
                     state <= RUN;
                  end
               end
               RUN: begin
                  DO_VALID <= 1'b1;
                  DO       <= cand;
                  TW_IDX   <= cand_tw;
                  DO_DIFF  <= cand_diff;
               end
               default: state <= FILL;
            endcase
         end
      end
   end

endmodule

// File: doc/r2sdf_bf_stage.md
Name: r2sdf_bf_stage

Overview:
- One radix-2 decimation-in-frequency stage of the streaming single-path delay-feedback FFT.
- Sits directly upstream of the complex twiddle multiplier. It supplies the multiplier's A operand (DO) and the twiddle ROM address (TW_IDX) that selects its W operand.
- Consumes one complex sample per valid beat. Produces butterfly sums and differences in the same packed format, scaled by 1/2 per stage to prevent overflow.

Parameters:
- DEPTH, 8, feedback delay length in samples. Power of two, >=1. Butterfly span; the stage frame is 2*DEPTH samples.
- TW_W, 3, width of the twiddle ROM address.
- TW_STRIDE, 1, twiddle index step per difference sample. Requires (DEPTH-1)*TW_STRIDE < 2**TW_W.

Ports:
- CLK  in  1  clock. One clock; all state changes on its rising edge.
- RST  in  1  reset. Synchronous, active-high.
- DI_VALID  in  1  DI carries a sample this cycle. No backpressure; every valid beat is accepted.
- DI  in  32  input sample {re[31:16], im[15:0]}, signed Q2.14 two's complement.
- DO_VALID  out  1  DO/TW_IDX/DO_DIFF are valid.
- DO  out  32  output sample, same packing; feeds the multiplier's A.
- TW_IDX  out  TW_W  twiddle ROM address for DO; 0 selects W^0 = 1.
- DO_DIFF  out  1  1 when DO is a difference term (twiddled); 0 for a sum term.

Behaviour:
- Reset values: all outputs 0, including DO_VALID, DO, TW_IDX and DO_DIFF. cnt=0; state=FILL. Delay-line contents are not reset; stale contents are never output because of FILL gating.
- Counter cnt: log2(2*DEPTH) bits. Increments only on DI_VALID and wraps 2*DEPTH-1 -> 0.
  - phase = cnt MSB.
  - k = cnt low bits (0..DEPTH-1).
- Delay line: DEPTH x 32 FIFO. On each valid beat it pushes one word and pops the word pushed DEPTH valid beats earlier (d). Idle cycles do not advance it.
- Phase 0 (cnt<DEPTH), on each valid beat:
  - push DI;
  - output candidate = d, which is the stored difference of the previous frame;
  - DO_DIFF=1, TW_IDX = k*TW_STRIDE (truncated to TW_W bits).
- Phase 1 (cnt>=DEPTH), on each valid beat:
  - a = d (sample k), b = DI (sample k+DEPTH);
  - output candidate = (a+b)>>>1, DO_DIFF=0, TW_IDX=0;
  - push (a-b)>>>1.
- Arithmetic:
  - re and im are handled independently.
  - Each is sign-extended to 17 bits, then added/subtracted; the result is bits [16:1] (arithmetic shift, rounds toward -inf). No saturation is needed.
  - Example: (-32768) + (-32768) -> -32768.
- State machine:
  - FILL -> RUN on the valid beat that takes cnt from DEPTH-1 to DEPTH.
  - RUN is held until RST.
  - In FILL, candidates are discarded.
- Output register:
  - In RUN, DO/TW_IDX/DO_DIFF are registered from the candidate, and DO_VALID=1, in the cycle after each accepted beat.
  - DO_VALID=0 after idle beats. DO/TW_IDX/DO_DIFF hold their last value when DO_VALID=0.
- Latency: 1 cycle from DI beat to DO.
  - Sample k's sum appears 1 cycle after input k+DEPTH.
  - Its difference appears 1 cycle after input k of the next frame.
- Drain: the last frame's differences leave only when DEPTH further valid beats arrive. The upstream feeds zero samples to flush.
- Simultaneous events: RST wins over DI_VALID. That beat is dropped, and cnt/state/outputs return to their reset values next cycle.
- Reset mid-frame: partial frame discarded; the next valid beat is treated as sample 0 in FILL.

Decomposition:
- Shared package fft_pkg:
  - DW=16, CPLX_W=32;
  - packed complex typedef {re,im};
  - half_add/half_sub functions (17-bit sign-extend, take [16:1]).
- The twiddle multiplier also uses fft_pkg.
- One sub-module: sdf_delay_line. Parameter DEPTH. Ports: CLK, EN, D in, Q out. Circular RAM or shift register, advancing only on EN.

Test Plan:
1. Reset then DEPTH=2, TW_STRIDE=1.
   - Stimulus: feed re=100,200,300,400 (im=0) on 4 consecutive cycles.
   - Required: DO_VALID low for the first 2 outputs. Then DO re=200, then 300, with DO_DIFF=0 and TW_IDX=0.
2. Continue scenario 1 with 0,0,0,0.
   - Required: outputs re=-100 with TW_IDX=0, then re=-100 with TW_IDX=1, both DO_DIFF=1. Then two sums of 0.
3. DEPTH=8, TW_STRIDE=2, impulse (re=16384 at sample 0, others 0) plus one flush frame.
   - Required: sums re=8192 at k=0, then 0.
   - Required: differences re=8192 at k=0 (TW_IDX=0), then 0 with TW_IDX=2,4,...,14.
4. Overflow corner.
   - Stimulus: a=b=0x80008000 (re=im=-32768).
   - Required: sum re=im=-32768; difference 0.
   - Stimulus: a=0x7FFF7FFF, b=0x80008000.
   - Required: difference re=im=32767; sum re=im=-1.
5. DI_VALID toggling 1,0,1,0 with scenario-1 data.
   - Required: identical DO sequence to scenario 1, each DO_VALID pulse one cycle after its accepted beat, and no output on idle cycles.
6. Reset mid-frame.
   - Stimulus: assert RST after 3 samples of a RUN frame, together with DI_VALID=1.
   - Required: DO_VALID=0 next cycle; the following DEPTH beats produce no output; then correct sums for the new frame.
